// File: rtl/boot_host_if.sv
// Bus bundle for boot_host: request/status handshake, image-memory read port and UART lines.
interface boot_host_if;
  logic       ce;
  logic       start;
  logic [7:0] length;
  logic       mem_en;
  logic [7:0] mem_adr;
  logic [7:0] mem_data;
  logic       tx;
  logic       rx;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    input  ce, start, length, mem_data, rx,
    output mem_en, mem_adr, tx, busy, done, error
  );

  modport slave (
    output ce, start, length, mem_data, rx,
    input  mem_en, mem_adr, tx, busy, done, error
  );
endinterface

// File: rtl/boot_host.sv
// Streams a boot image over 8N1 UART (sync, length, data, checksum) and waits for ACK/NAK.
module boot_host #(
  parameter int CLK_DIV = 87,
  parameter int TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  boot_host_if.master  bus
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BAUD_MID  = BW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SEND_SYNC, SEND_LEN, FETCH, SEND_DATA, SEND_SUM, WAIT_RESP, DONE
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    len_q, adr_q, sum_q;
  logic          fetch_ph;
  logic          done_q, error_q;
  logic [TW-1:0] to_cnt;

  logic [9:0]    tx_sr;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic          tx_run, tx_done;

  logic          rx_m, rx_s, rx_prev;
  logic          rx_run, rx_valid;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sr;

  logic          accept, frame_load, capture, adr_inc, finish, fail;
  logic [7:0]    frame_byte;

  // Last ce-cycle of the stop bit; the next frame is loaded on this same edge.
  assign tx_done = tx_run && (tx_bit == 4'd9) && (tx_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst)         state <= IDLE;
    else if (bus.ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    frame_load = 1'b0;
    frame_byte = 8'hA5;
    capture    = 1'b0;
    adr_inc    = 1'b0;
    finish     = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          frame_load = 1'b1;
          frame_byte = 8'hA5;
          state_nxt  = SEND_SYNC;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      SEND_SYNC: begin
        if (tx_done) begin
          frame_load = 1'b1;
          frame_byte = len_q;
          state_nxt  = SEND_LEN;
        end
      end
      SEND_LEN: begin
        if (tx_done) state_nxt = FETCH;
      end
      FETCH: begin
        if (fetch_ph) begin
          capture    = 1'b1;
          frame_load = 1'b1;
          frame_byte = bus.mem_data;
          state_nxt  = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (tx_done) begin
          // len_q of 0 means 256 bytes, so the last address wraps to 255
          if (adr_q == len_q - 8'd1) begin
            frame_load = 1'b1;
            frame_byte = sum_q;
            state_nxt  = SEND_SUM;
          end else begin
            adr_inc   = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      SEND_SUM: begin
        if (tx_done) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        // A byte landing on the final timeout cycle takes precedence
        if (rx_valid) begin
          finish    = 1'b1;
          fail      = (rx_sr != 8'h06);
          state_nxt = DONE;
        end else if (to_cnt == TO_LAST) begin
          finish    = 1'b1;
          fail      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      adr_q    <= '0;
      sum_q    <= '0;
      fetch_ph <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      to_cnt   <= '0;
      tx_sr    <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_run   <= 1'b0;
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_run   <= 1'b0;
      rx_valid <= 1'b0;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_sr    <= '0;
    end else if (bus.ce) begin
      if (accept) begin
        len_q   <= bus.length;
        adr_q   <= '0;
        sum_q   <= '0;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end
      if (adr_inc) adr_q <= adr_q + 8'd1;
      if (capture) sum_q <= sum_q + bus.mem_data;
      if (finish) begin
        done_q  <= 1'b1;
        error_q <= fail;
      end
      fetch_ph <= (state == FETCH) && !fetch_ph;
      to_cnt   <= (state == WAIT_RESP) ? to_cnt + 1'b1 : '0;

      // Transmitter: shifting in ones leaves the line idle-high after the stop bit
      if (frame_load) begin
        tx_sr   <= {1'b1, frame_byte, 1'b0};
        tx_baud <= '0;
        tx_bit  <= '0;
        tx_run  <= 1'b1;
      end else if (tx_run) begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud <= '0;
          tx_sr   <= {1'b1, tx_sr[9:1]};
          tx_bit  <= tx_bit + 4'd1;
          if (tx_bit == 4'd9) tx_run <= 1'b0;
        end else begin
          tx_baud <= tx_baud + 1'b1;
        end
      end

      // Receiver: start bit re-checked at mid-bit, then sampled every CLK_DIV
      rx_m     <= bus.rx;
      rx_s     <= rx_m;
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      if (!rx_run) begin
        if (rx_prev && !rx_s) begin
          rx_run  <= 1'b1;
          rx_baud <= '0;
          rx_bit  <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        if (rx_baud == BAUD_MID) begin
          rx_baud <= '0;
          if (rx_s) rx_run <= 1'b0;
          else      rx_bit <= 4'd1;
        end else begin
          rx_baud <= rx_baud + 1'b1;
        end
      end else if (rx_baud == BAUD_LAST) begin
        rx_baud <= '0;
        if (rx_bit == 4'd9) begin
          rx_run   <= 1'b0;
          rx_valid <= rx_s;
        end else begin
          rx_sr  <= {rx_s, rx_sr[7:1]};
          rx_bit <= rx_bit + 4'd1;
        end
      end else begin
        rx_baud <= rx_baud + 1'b1;
      end
    end
  end

  assign bus.mem_en  = (state == FETCH) && !fetch_ph;
  assign bus.mem_adr = adr_q;
  assign bus.tx      = tx_sr[0];
  assign bus.busy    = (state != IDLE) && (state != DONE);
  assign bus.done    = done_q;
  assign bus.error   = error_q;

endmodule

// File: tb/tb_boot_host.sv
// Scoreboarded bench for boot_host: decodes tx frames against queued expected bytes, plays the target.
module tb_boot_host;
  localparam int D  = 4;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  boot_host_if bif();

  boot_host #(.CLK_DIV(D), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int mon_raw = 0;
  bit ce_div3 = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Image memory: one ce-cycle read latency
  always @(posedge clk) if (bif.ce && bif.mem_en) bif.mem_data <= mem[bif.mem_adr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  initial begin : ce_drv
    int ph;
    ph = 0;
    bif.ce = 1'b1;
    forever begin
      @(negedge clk);
      if (ce_div3) begin
        ph = (ph == 2) ? 0 : ph + 1;
        bif.ce = (ph == 0);
      end else begin
        bif.ce = 1'b1;
      end
    end
  end

  // tx decoder, counting ce-qualified cycles from the first low sample
  initial begin : tx_mon
    int c, raw;
    bit ab;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (rst || bif.tx !== 1'b0) continue;
      c = 0; raw = 0; ab = 1'b0; bits = '0;
      for (int k = 0; k < 10 && !ab; k++) begin
        while (c < k * D + D / 2 && !ab) begin
          @(posedge clk);
          raw++;
          if (rst) ab = 1'b1;
          else if (bif.ce) c++;
          @(negedge clk);
        end
        bits[k] = bif.tx;
      end
      if (!ab) begin
        mon_raw  = raw;
        stop_cyc = cyc;
        check("tx_start_bit", bits[0], 0);
        check("tx_stop_bit", bits[9], 1);
        if (exp_q.size() == 0) check("tx_extra_byte", bits[8:1], 32'h100);
        else check("tx_byte", bits[8:1], exp_q.pop_front());
      end
    end
  end

  task automatic start_xfer(input int n);
    int sum;
    int t;
    sum = 0;
    @(negedge clk);
    bif.start  = 1'b1;
    bif.length = 8'(n);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[i]);
      sum += int'(mem[i]);
    end
    exp_q.push_back(8'(sum));
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bif.busy && t < 10);
    bif.start = 1'b0;
    check("start_accepted", bif.busy, 1);
  endtask

  task automatic wait_q_empty(input int bound);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    check("frames_drained", exp_q.size(), 0);
  endtask

  task automatic wait_done(input int bound, output int at);
    int t;
    t = 0;
    while (bif.done !== 1'b1 && t < bound) begin
      @(negedge clk);
      t++;
    end
    at = cyc;
    check("done_seen", bif.done, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop, input int mult);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      bif.rx = f[k];
      repeat (D * mult) @(negedge clk);
    end
    bif.rx = 1'b1;
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  initial begin : main
    int t;
    int zeros;
    bif.start  = 1'b0;
    bif.length = 8'h00;
    bif.rx     = 1'b1;
    rst        = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    repeat (3) @(negedge clk);
    check("rst_tx", bif.tx, 1);
    check("rst_busy", bif.busy, 0);
    check("rst_done", bif.done, 0);
    check("rst_error", bif.error, 0);
    check("rst_mem_en", bif.mem_en, 0);
    check("rst_mem_adr", bif.mem_adr, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // ACK path: A5 03 10 20 30 60
    start_xfer(3);
    wait_q_empty(2000);
    repeat (2) @(negedge clk);
    send_rx(8'h06, 1'b1, 1);
    wait_done(500, t);
    check("ack_error", bif.error, 0);
    check("ack_busy", bif.busy, 0);
    repeat (3) @(negedge clk);
    check("ack_done_sticky", bif.done, 1);

    // NAK path
    start_xfer(3);
    wait_q_empty(2000);
    repeat (2) @(negedge clk);
    send_rx(8'h15, 1'b1, 1);
    wait_done(500, t);
    check("nak_error", bif.error, 1);
    repeat (2) @(negedge clk);

    // New start clears sticky flags; then no reply with a framing-error glitch
    start_xfer(3);
    check("restart_done_clr", bif.done, 0);
    check("restart_error_clr", bif.error, 0);
    wait_q_empty(2000);
    send_rx(8'h55, 1'b0, 1);
    check("glitch_ignored", bif.done, 0);
    wait_done(1000, t);
    check("timeout_cycles", t - stop_cyc, D - 2 + TO);
    check("timeout_error", bif.error, 1);
    repeat (2) @(negedge clk);

    // 256-byte image: length byte 00, checksum 80
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    start_xfer(256);
    wait_q_empty(15000);
    check("full_last_adr", bif.mem_adr, 255);
    repeat (2) @(negedge clk);
    send_rx(8'h06, 1'b1, 1);
    wait_done(500, t);
    check("full_error", bif.error, 0);
    repeat (2) @(negedge clk);

    // ce asserted one cycle in three
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h30;
    ce_div3 = 1'b1;
    start_xfer(3);
    wait_q_empty(6000);
    check("ce_stretch", (mon_raw >= 3 * (9 * D + 1)), 1);
    repeat (6) @(negedge clk);
    send_rx(8'h06, 1'b1, 3);
    wait_done(3000, t);
    check("ce_error", bif.error, 0);
    ce_div3 = 1'b0;
    repeat (6) @(negedge clk);

    // Reset in the middle of the length frame's data bits
    start_xfer(3);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", bif.tx, 1);
    check("rst_mid_busy", bif.busy, 0);
    check("rst_mid_adr", bif.mem_adr, 0);
    rst = 1'b0;
    exp_q.delete();
    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (bif.tx !== 1'b1) zeros++;
    end
    check("rst_no_resume", zeros, 0);
    check("rst_idle_busy", bif.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
